// File: rtl/r200_dmem_resp.sv
// r200_dmem_resp -- data-memory responder for the r200 MEM stage.
//
// Accepts one load/store request at a time. It holds the request for
// WAIT_CYCLES wait states. It then commits the store or reads the word
// from the internal array, applying RISC-V byte-lane selection and
// sign/zero extension. The result is returned through a valid/ready
// response handshake. There is no pipelining: the next request is taken
// only after the response handshake.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words in the array (power of two, >= 2)
//   WAIT_CYCLES  wait states between accept and response (0..15)
//   BASE_ADDR    byte address of word 0 (word aligned)
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   req_valid/ready    request handshake (ready only in IDLE)
//   req_addr           byte address
//   req_we             1 = store, 0 = load
//   req_func3          RISC-V funct3 (B/H/W/BU/HU)
//   req_wdata          right-aligned store data
//   resp_valid/ready   response handshake
//   resp_rdata         extended load data; 0 for stores and faults
//   resp_err           access fault
//
// Build option: define R200_DMEM_MISALIGN_EN to fault misaligned halfword
// and word accesses. Without it, these accesses are silently aligned down.

module r200_dmem_resp #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] addr_reg, wdata_reg;
  logic        we_reg;
  logic [2:0]  func3_reg;
  logic        err_reg;

  logic        accept;
  logic        commit;

  // Request fields as seen at the commit edge. With zero wait states, the
  // commit edge is the accept edge itself. The latched copy is not yet
  // loaded at that point, so the live request is used instead.
  logic [31:0] acc_addr, acc_wdata;
  logic        acc_we;
  logic [2:0]  acc_func3;
  logic [29:0] acc_word_off;
  logic        acc_err;
  logic        acc_store_ok;
  logic [AW-1:0] word_idx;
  logic [31:0] rd_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;

  assign req_ready  = (state_reg == IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_reg == RESP);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) state_next = RESP;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset has priority over a commit that falls on the same edge.
  assign commit = !rst && (state_reg != RESP) && (state_next == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (commit) err_reg <= acc_err;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_reg  <= req_addr;
      we_reg    <= req_we;
      func3_reg <= req_func3;
      wdata_reg <= req_wdata;
    end
  end

  always_comb begin
    acc_addr  = addr_reg;
    acc_we    = we_reg;
    acc_func3 = func3_reg;
    acc_wdata = wdata_reg;
    if (state_reg == IDLE) begin
      acc_addr  = req_addr;
      acc_we    = req_we;
      acc_func3 = req_func3;
      acc_wdata = req_wdata;
    end
  end

  // Work in word units so the range check needs no byte offset bits.
  assign acc_word_off = acc_addr[31:2] - BASE_ADDR[31:2];
  assign word_idx     = acc_word_off[AW-1:0];

  always_comb begin
    acc_err = 1'b0;
    if (acc_addr < BASE_ADDR || acc_word_off >= 30'(DEPTH_WORDS)) acc_err = 1'b1;
    if (acc_func3 == 3'b011 || acc_func3 == 3'b110 || acc_func3 == 3'b111) acc_err = 1'b1;
    if (acc_we && acc_func3[2]) acc_err = 1'b1;
`ifdef R200_DMEM_MISALIGN_EN
    if (acc_func3[1:0] == 2'b01 && acc_addr[0]) acc_err = 1'b1;
    if (acc_func3[1:0] == 2'b10 && acc_addr[1:0] != 2'b00) acc_err = 1'b1;
`endif
  end

  assign acc_store_ok = acc_we && !acc_err;

  // One byte-wide array per lane. This gives each lane its own write
  // enable, and its read register is loaded on the commit edge.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_q;
      logic       lane_sel;
      logic [7:0] lane_wdata;

      always_comb begin
        lane_sel   = 1'b0;
        lane_wdata = acc_wdata[8*gi +: 8];
        case (acc_func3[1:0])
          2'b00: begin
            lane_sel   = (acc_addr[1:0] == LANE);
            lane_wdata = acc_wdata[7:0];
          end
          2'b01: begin
            lane_sel   = (acc_addr[1] == LANE[1]);
            lane_wdata = acc_wdata[8*(gi % 2) +: 8];
          end
          2'b10:   lane_sel = 1'b1;
          default: lane_sel = 1'b0;
        endcase
      end

      always_ff @(posedge clk) begin
        if (commit) begin
          if (acc_store_ok && lane_sel) mem[word_idx] <= lane_wdata;
          rd_q <= mem[word_idx];
        end
      end
    end
  endgenerate

  assign rd_word  = {g_lane[3].rd_q, g_lane[2].rd_q, g_lane[1].rd_q, g_lane[0].rd_q};
  assign byte_sel = 8'(rd_word >> {addr_reg[1:0], 3'b000});
  assign half_sel = addr_reg[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (func3_reg)
      3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ext_data = {24'd0, byte_sel};
      3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  ext_data = {16'd0, half_sel};
      3'b010:  ext_data = rd_word;
      default: ext_data = 32'd0;
    endcase
  end

  assign resp_rdata = (resp_valid && !err_reg && !we_reg) ? ext_data : 32'd0;
  assign resp_err   = resp_valid && err_reg;

endmodule
